alu_seq_param: RTL and testbench
================================

Name: alu_seq_param

Overview:
Parametrised sequential ALU, the successor to the fixed 8-bit add/multiply ALU.
- Operands arrive serially on a shared input bus after a BEGIN request.
- Supports ADD, SUB, unsigned MUL (shift-add) and unsigned DIV (restoring).
- Returns an exact 2*WIDTH-bit result over two output cycles, flagged by out_valid and END.
- Sits between the bus controller and the register file as the design's only arithmetic unit.

Parameters:
- WIDTH, 8, operand and bus width in bits; must be >= 2.
- CNT_W, $clog2(WIDTH)+1, iteration counter width. Derived; never overridden.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset. Asserting it (0) clears all state immediately.
- BEGIN  input  1  start request; sampled only in IDLE.
- op_code  input  2  operation select: 00 ADD, 01 SUB, 10 MUL, 11 DIV. Captured with BEGIN.
- inbus  input  WIDTH  operand input: A on the first load cycle, B on the second.
- outbus  output  WIDTH  result word; all zeros when out_valid=0.
- out_valid  output  1  outbus carries a result word.
- END  output  1  high only during the final (high-word) output cycle.
- busy  output  1  high in every state except IDLE.
- err  output  1  divide-by-zero flag; valid only while out_valid=1, otherwise 0.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; A, B, accumulator, counter and op register are cleared; outbus=0, out_valid=0, END=0, busy=0, err=0.
- States: IDLE, LOAD_A, LOAD_B, EXEC, OUT_LO, OUT_HI.
- IDLE: at an edge with BEGIN=1, capture op_code and go to LOAD_A. BEGIN=0 keeps the block in IDLE.
- LOAD_A: next edge latches A<=inbus and goes to LOAD_B.
- LOAD_B: next edge latches B<=inbus, clears the counter and goes to EXEC.
- EXEC, ADD/SUB: one edge, then OUT_LO.
- EXEC, MUL/DIV: exactly WIDTH edges, counting 0..WIDTH-1, then OUT_LO.
- OUT_LO: lasts 1 cycle, then OUT_HI.
- OUT_HI: lasts 1 cycle, then IDLE.
- Latency from the BEGIN-capturing edge to OUT_LO entry: 3 edges for ADD/SUB, WIDTH+2 edges for MUL/DIV.
- Result words (low word in OUT_LO, high word in OUT_HI):
  - ADD: low=(A+B)[W-1:0]; high=carry zero-extended.
  - SUB: low=(A-B)[W-1:0]; high=all ones if A<B, else zero. Together they form the 2W-bit two's-complement difference.
  - MUL: shift-add, one partial product per EXEC cycle. low=product[W-1:0], high=product[2W-1:W].
  - DIV: restoring, one quotient bit per EXEC cycle. low=quotient, high=remainder.
  - DIV with B=0: still runs WIDTH cycles; low=all ones, high=A, err=1 in both output cycles.
- out_valid=1 in OUT_LO and OUT_HI only. END=1 in OUT_HI only.
- BEGIN outside IDLE is ignored; op_code and inbus are don't-care outside their capture edges.
- If BEGIN is still high on the edge that returns the block to IDLE, it is not sampled. It is sampled on the following edge, so the minimum gap between results is one IDLE cycle.
- Reset during any state aborts the operation; no partial result is ever presented.
- All arithmetic is unsigned and modulo 2^(2W); there is no overflow flag.

Decomposition:
- Package alu_pkg holds:
  - op_code localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11;
  - state encoding localparams for the six states.
- One sub-module, alu_seq_datapath, contains A/B registers, the 2W-bit accumulator, the adder/subtractor, the shift logic and the counter. It is driven by load/step/clear strobes from the FSM in alu_seq_param.

Test Plan:
- WIDTH=8, ADD, A=3, B=2 -> OUT_LO outbus=5; OUT_HI outbus=0 with END=1, err=0; OUT_LO on the 3rd edge after BEGIN capture.
- WIDTH=8, SUB, A=2, B=3 -> low=0xFF, high=0xFF. Then ADD A=200, B=100 -> low=0x2C, high=0x01.
- WIDTH=8, MUL: A=7, B=3 -> low=21, high=0; A=200, B=200 -> low=0x40, high=0x9C; OUT_LO exactly 10 edges after BEGIN capture.
- WIDTH=8, DIV: A=100, B=7 -> low=14, high=2, err=0. A=9, B=0 -> low=0xFF, high=9, err=1 in both output cycles, then err=0 in IDLE.
- Reset pulled low mid-MUL (EXEC count 4), asynchronous between clock edges -> outputs are 0 immediately and state is IDLE. A following ADD 1+1 returns low=2.
- WIDTH=16, MUL 0xFFFF*0xFFFF -> low=0x0001, high=0xFFFE, 18 edges latency. BEGIN held high throughout -> second operation starts one IDLE cycle after OUT_HI.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes and FSM state encoding.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [2:0] ENC_IDLE   = 3'd0;
    localparam logic [2:0] ENC_LOAD_A = 3'd1;
    localparam logic [2:0] ENC_LOAD_B = 3'd2;
    localparam logic [2:0] ENC_EXEC   = 3'd3;
    localparam logic [2:0] ENC_OUT_LO = 3'd4;
    localparam logic [2:0] ENC_OUT_HI = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = ENC_IDLE,
        ST_LOAD_A = ENC_LOAD_A,
        ST_LOAD_B = ENC_LOAD_B,
        ST_EXEC   = ENC_EXEC,
        ST_OUT_LO = ENC_OUT_LO,
        ST_OUT_HI = ENC_OUT_HI
    } state_t;

endpackage

// File: rtl/alu_seq_datapath.sv
// Operand registers, 2W-bit accumulator and iteration counter of the sequential ALU.
// The accumulator holds {high word, low word}; MUL and DIV shift through it one bit per step.
module alu_seq_datapath
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         op,
    input  logic               load_a,
    input  logic               load_b,
    input  logic               step,
    input  logic [WIDTH-1:0]   inbus,
    output logic [2*WIDTH-1:0] acc,
    output logic               cnt_done,
    output logic               div_zero
);

    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_part;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] acc_next;

    // MUL: multiplier sits in the low half and is consumed LSB first while the
    // partial sum (with its carry) shifts down from the high half.
    // DIV: remainder in the high half, dividend/quotient in the low half;
    // a borrow from the trial subtraction means the old remainder is restored.
    always_comb begin
        mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, a_reg} : '0);
        div_part  = acc_reg[2*WIDTH-1:WIDTH-1];
        div_trial = div_part - {1'b0, b_reg};
        acc_next  = acc_reg;
        case (op)
            OP_ADD:  acc_next = {{WIDTH{1'b0}}, a_reg} + {{WIDTH{1'b0}}, b_reg};
            OP_SUB:  acc_next = {{WIDTH{1'b0}}, a_reg} - {{WIDTH{1'b0}}, b_reg};
            OP_MUL:  acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
            default: acc_next = div_trial[WIDTH]
                              ? {div_part[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                              : {div_trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
        endcase
    end

    // Loading B seeds the accumulator for the iterative operations and restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_reg   <= '0;
            b_reg   <= '0;
            acc_reg <= '0;
            cnt     <= '0;
        end else begin
            if (load_a) begin
                a_reg <= inbus;
            end
            if (load_b) begin
                b_reg   <= inbus;
                cnt     <= '0;
                acc_reg <= (op == OP_MUL) ? {{WIDTH{1'b0}}, inbus} : {{WIDTH{1'b0}}, a_reg};
            end else if (step) begin
                acc_reg <= acc_next;
                cnt     <= cnt + CNT_W'(1);
            end
        end
    end

    assign acc      = acc_reg;
    assign cnt_done = (cnt == CNT_W'(WIDTH - 1));
    assign div_zero = (b_reg == '0);

endmodule

// File: rtl/alu_seq_param.sv
// Sequential ALU top: control FSM sequencing operand load, execution and the
// two-cycle result presentation (low word, then high word with END).
module alu_seq_param
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             BEGIN,
    input  logic [1:0]       op_code,
    input  logic [WIDTH-1:0] inbus,
    output logic [WIDTH-1:0] outbus,
    output logic             out_valid,
    output logic             END,
    output logic             busy,
    output logic             err
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             state;
    state_t             state_next;
    logic [1:0]         op_reg;
    logic               load_a;
    logic               load_b;
    logic               step;
    logic [2*WIDTH-1:0] acc;
    logic               cnt_done;
    logic               div_zero;

    alu_seq_datapath #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_datapath (
        .clk      (clk),
        .reset    (reset),
        .op       (op_reg),
        .load_a   (load_a),
        .load_b   (load_b),
        .step     (step),
        .inbus    (inbus),
        .acc      (acc),
        .cnt_done (cnt_done),
        .div_zero (div_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            op_reg <= OP_ADD;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && BEGIN) begin
                op_reg <= op_code;
            end
        end
    end

    // ADD/SUB finish in a single EXEC cycle; MUL/DIV stay until the counter hits WIDTH-1.
    always_comb begin
        state_next = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        step       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (BEGIN) begin
                    state_next = ST_LOAD_A;
                end
            end
            ST_LOAD_A: begin
                load_a     = 1'b1;
                state_next = ST_LOAD_B;
            end
            ST_LOAD_B: begin
                load_b     = 1'b1;
                state_next = ST_EXEC;
            end
            ST_EXEC: begin
                step = 1'b1;
                if (!op_reg[1] || cnt_done) begin
                    state_next = ST_OUT_LO;
                end
            end
            ST_OUT_LO: state_next = ST_OUT_HI;
            ST_OUT_HI: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == ST_OUT_LO) || (state == ST_OUT_HI);
        END       = (state == ST_OUT_HI);
        busy      = (state != ST_IDLE);
        outbus    = '0;
        if (state == ST_OUT_LO) begin
            outbus = acc[WIDTH-1:0];
        end else if (state == ST_OUT_HI) begin
            outbus = acc[2*WIDTH-1:WIDTH];
        end
        err = out_valid && (op_reg == OP_DIV) && div_zero;
    end

endmodule

// File: tb/tb_alu_seq_param.sv
// Self-checking bench for alu_seq_param: an 8-bit and a 16-bit instance share one clock;
// expected results come from a behavioural model through a per-instance scoreboard queue.
module tb_alu_seq_param;
    import alu_pkg::*;

    typedef struct {
        logic [15:0] lo;
        logic [15:0] hi;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst8, begin8, valid8, end8, busy8, err8;
    logic [1:0]  op8;
    logic [7:0]  in8, out8;
    logic        rst16, begin16, valid16, end16, busy16, err16;
    logic [1:0]  op16;
    logic [15:0] in16, out16;

    exp_t q8[$];
    exp_t q16[$];
    int   n_total = 0;
    int   n_bad   = 0;

    alu_seq_param #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(rst8), .BEGIN(begin8), .op_code(op8), .inbus(in8),
        .outbus(out8), .out_valid(valid8), .END(end8), .busy(busy8), .err(err8)
    );

    alu_seq_param #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(rst16), .BEGIN(begin16), .op_code(op16), .inbus(in16),
        .outbus(out16), .out_valid(valid16), .END(end16), .busy(busy16), .err(err16)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_total++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic exp_t model(input int w, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        longint unsigned la   = 64'(a);
        longint unsigned lb   = 64'(b);
        longint unsigned mask = (64'd1 << w) - 1;
        longint unsigned full = (64'd1 << (2 * w)) - 1;
        longint unsigned r;
        exp_t e;
        case (op)
            OP_ADD:  r = la + lb;
            OP_SUB:  r = (la - lb) & full;
            OP_MUL:  r = la * lb;
            default: r = (lb == 0) ? ((la << w) | mask) : (((la % lb) << w) | (la / lb));
        endcase
        e.lo  = 16'(r & mask);
        e.hi  = 16'((r >> w) & mask);
        e.err = (op == OP_DIV) && (lb == 0);
        return e;
    endfunction

    task automatic sampleOut(input int inst, output logic [15:0] ob, output logic ov,
                             output logic en, output logic bz, output logic er);
        if (inst == 0) begin
            ob = {8'h00, out8}; ov = valid8; en = end8; bz = busy8; er = err8;
        end else begin
            ob = out16; ov = valid16; en = end16; bz = busy16; er = err16;
        end
    endtask

    task automatic driveBegin(input int inst, input logic bg, input logic [1:0] op);
        if (inst == 0) begin begin8 = bg; op8 = op; end
        else begin begin16 = bg; op16 = op; end
    endtask

    task automatic driveBus(input int inst, input logic [15:0] data);
        if (inst == 0) in8 = data[7:0];
        else in16 = data;
    endtask

    // Called #1 after an edge with the DUT in IDLE; returns #1 after the LOAD_B edge.
    task automatic applyStimulus(input int inst, input logic [1:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic hold);
        exp_t e;
        e = model((inst == 0) ? 8 : 16, op, a, b);
        if (inst == 0) q8.push_back(e);
        else q16.push_back(e);
        driveBegin(inst, 1'b1, op);
        @(posedge clk); #1;
        driveBegin(inst, hold, op);
        driveBus(inst, a);
        @(posedge clk); #1;
        driveBus(inst, b);
        @(posedge clk); #1;
    endtask

    task automatic checkResult(input int inst, input int lat);
        int          edges;
        exp_t        e;
        logic [15:0] ob;
        logic        ov, en, bz, er;
        string       p;
        p     = (inst == 0) ? "w8" : "w16";
        edges = 2;
        sampleOut(inst, ob, ov, en, bz, er);
        while (!ov && edges < lat + 8) begin
            @(posedge clk); #1;
            edges++;
            sampleOut(inst, ob, ov, en, bz, er);
        end
        checkOutput({p, "_latency"}, edges, lat);
        if ((inst == 0 && q8.size() == 0) || (inst == 1 && q16.size() == 0)) begin
            checkOutput({p, "_sb_underflow"}, 1, 0);
        end else begin
            e = (inst == 0) ? q8.pop_front() : q16.pop_front();
            checkOutput({p, "_lo"}, ob, e.lo);
            checkOutput({p, "_lo_err"}, er, e.err);
            checkOutput({p, "_lo_end"}, en, 0);
            @(posedge clk); #1;
            sampleOut(inst, ob, ov, en, bz, er);
            checkOutput({p, "_hi"}, ob, e.hi);
            checkOutput({p, "_hi_err"}, er, e.err);
            checkOutput({p, "_hi_end"}, en, 1);
            checkOutput({p, "_hi_valid"}, ov, 1);
        end
        @(posedge clk); #1;
        sampleOut(inst, ob, ov, en, bz, er);
        checkOutput({p, "_idle_valid"}, ov, 0);
        checkOutput({p, "_idle_err"}, er, 0);
        checkOutput({p, "_idle_busy"}, bz, 0);
        checkOutput({p, "_idle_outbus"}, ob, 0);
    endtask

    initial begin
        logic [15:0] ob;
        logic        ov, en, bz, er;

        rst8 = 1'b0; begin8 = 1'b0; op8 = OP_ADD; in8 = '0;
        rst16 = 1'b0; begin16 = 1'b0; op16 = OP_ADD; in16 = '0;
        #2;
        for (int i = 0; i < 2; i++) begin
            sampleOut(i, ob, ov, en, bz, er);
            checkOutput("rst_outbus", ob, 0);
            checkOutput("rst_valid", ov, 0);
            checkOutput("rst_end", en, 0);
            checkOutput("rst_busy", bz, 0);
            checkOutput("rst_err", er, 0);
        end
        #10;
        rst8 = 1'b1; rst16 = 1'b1;
        @(posedge clk); #1;

        applyStimulus(0, OP_ADD, 16'd3, 16'd2, 1'b0);     checkResult(0, 3);
        applyStimulus(0, OP_SUB, 16'd2, 16'd3, 1'b0);     checkResult(0, 3);
        applyStimulus(0, OP_ADD, 16'd200, 16'd100, 1'b0); checkResult(0, 3);
        applyStimulus(0, OP_MUL, 16'd7, 16'd3, 1'b0);     checkResult(0, 10);
        applyStimulus(0, OP_MUL, 16'd200, 16'd200, 1'b0); checkResult(0, 10);
        applyStimulus(0, OP_DIV, 16'd100, 16'd7, 1'b0);   checkResult(0, 10);
        applyStimulus(0, OP_DIV, 16'd9, 16'd0, 1'b0);     checkResult(0, 10);
        applyStimulus(0, OP_SUB, 16'd255, 16'd0, 1'b0);   checkResult(0, 3);

        // Abort a multiply four steps into EXEC with an asynchronous reset pulse.
        driveBegin(0, 1'b1, OP_MUL);
        @(posedge clk); #1;
        driveBegin(0, 1'b0, OP_MUL);
        driveBus(0, 16'd5);
        @(posedge clk); #1;
        driveBus(0, 16'd6);
        @(posedge clk); #1;
        repeat (4) @(posedge clk);
        #1;
        sampleOut(0, ob, ov, en, bz, er);
        checkOutput("abort_busy_before", bz, 1);
        #2;
        rst8 = 1'b0;
        #1;
        sampleOut(0, ob, ov, en, bz, er);
        checkOutput("abort_outbus", ob, 0);
        checkOutput("abort_valid", ov, 0);
        checkOutput("abort_busy", bz, 0);
        checkOutput("abort_end", en, 0);
        checkOutput("abort_err", er, 0);
        @(posedge clk); #2;
        rst8 = 1'b1;
        @(posedge clk); #1;
        applyStimulus(0, OP_ADD, 16'd1, 16'd1, 1'b0);     checkResult(0, 3);

        // BEGIN held high: the second operation is captured one IDLE cycle after OUT_HI.
        applyStimulus(1, OP_MUL, 16'hFFFF, 16'hFFFF, 1'b1); checkResult(1, 18);
        sampleOut(1, ob, ov, en, bz, er);
        checkOutput("w16_gap_busy", bz, 0);
        applyStimulus(1, OP_ADD, 16'h1234, 16'h0FFF, 1'b0); checkResult(1, 3);
        applyStimulus(1, OP_DIV, 16'hFFFF, 16'h0101, 1'b0); checkResult(1, 18);

        checkOutput("sb_drained", q8.size() + q16.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
